// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-operation, FSM state and control-word definitions
// for the control sequencer and its sub-blocks.
package ctrl_pkg;

    localparam int unsigned IR_W  = 32;
    localparam int unsigned OP_W  = 5;
    localparam int unsigned ALU_W = 4;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_LD   = 5'b00000;
    localparam opcode_t OP_ST   = 5'b00010;
    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_SUB  = 5'b00100;
    localparam opcode_t OP_AND  = 5'b00101;
    localparam opcode_t OP_OR   = 5'b00110;
    localparam opcode_t OP_ADDI = 5'b01100;
    localparam opcode_t OP_MUL  = 5'b01111;
    localparam opcode_t OP_DIV  = 5'b10000;
    localparam opcode_t OP_BR   = 5'b10010;
    localparam opcode_t OP_NOP  = 5'b11010;
    localparam opcode_t OP_HALT = 5'b11011;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_MUL = 4'd4,
        ALU_DIV = 4'd5
    } alu_op_t;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
    } state_t;

    // Instruction families that share one execute sequence
    typedef enum logic [3:0] {
        C_ALU, C_ADDI, C_LD, C_ST, C_BR, C_NOP, C_HALT, C_MULDIV, C_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic    pc_out;
        logic    zhi_out;
        logic    zlow_out;
        logic    mdr_out;
        logic    c_out;
        logic    ba_out;
        logic    r_out;
        logic    mar_in;
        logic    z_in;
        logic    pc_in;
        logic    mdr_in;
        logic    ir_in;
        logic    y_in;
        logic    hi_in;
        logic    lo_in;
        logic    r_in;
        logic    con_in;
        logic    gra;
        logic    grb;
        logic    grc;
        logic    inc_pc;
        logic    read;
        logic    write;
        alu_op_t alu_op;
        logic    run;
        logic    fault;
        logic    illegal_op;
    } ctrl_t;

    function automatic alu_op_t alu_for_op(input opcode_t op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath control bus: datapath status in, strobes and selects out.
interface control_sequencer_if;
    import ctrl_pkg::*;

    logic [IR_W-1:0]  IR;
    logic             CON;
    logic             MemReady;

    logic             PCout, Zhiout, Zlowout, MDRout, Cout, BAout, Rout;
    logic             MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Rin, CONIn;
    logic             Gra, Grb, Grc;
    logic             IncPC, Read, Write;
    logic [ALU_W-1:0] AluOp;
    logic             Run, Fault, IllegalOp;

    modport master (
        input  IR, CON, MemReady,
        output PCout, Zhiout, Zlowout, MDRout, Cout, BAout, Rout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Rin, CONIn,
        output Gra, Grb, Grc, IncPC, Read, Write, AluOp, Run, Fault, IllegalOp
    );

    modport slave (
        output IR, CON, MemReady,
        input  PCout, Zhiout, Zlowout, MDRout, Cout, BAout, Rout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Rin, CONIn,
        input  Gra, Grb, Grc, IncPC, Read, Write, AluOp, Run, Fault, IllegalOp
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts memory-wait cycles; expired flags the last permitted cycle that
// MemReady is still low so the sequencer can divert to FAULT on that edge.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != CNT_W'(LIMIT)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired fetch/execute control sequencer with memory-wait timeout.
// Define CTRL_MULDIV_EN to add the mul/div execute sequences (HI/LO results).
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                Clock,
    input  logic                Clear,
    control_sequencer_if.master bus
);

    state_t    state;
    op_class_t op_class;
    opcode_t   opcode;
    ctrl_t     ctl;
    logic      mem_wait;
    logic      wait_clear;
    logic      wait_en;
    logic      expired;

    assign opcode = bus.IR[IR_W-1 -: OP_W];

    logic unused_ir;
    assign unused_ir = ^bus.IR[IR_W-OP_W-1:0];

    always_comb begin
        op_class = C_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = C_ALU;
            OP_ADDI:                       op_class = C_ADDI;
            OP_LD:                         op_class = C_LD;
            OP_ST:                         op_class = C_ST;
            OP_BR:                         op_class = C_BR;
            OP_NOP:                        op_class = C_NOP;
            OP_HALT:                       op_class = C_HALT;
`ifdef CTRL_MULDIV_EN
            OP_MUL, OP_DIV:                op_class = C_MULDIV;
`endif
            default:                       op_class = C_ILLEGAL;
        endcase
    end

    // Fetch read (T1/T1W) is one wait window; ld T6 and st T7 are the others
    always_comb begin
        mem_wait = 1'b0;
        case (state)
            S_T1, S_T1W: mem_wait = 1'b1;
            S_T6:        mem_wait = (op_class == C_LD);
            S_T7:        mem_wait = (op_class == C_ST);
            default:     mem_wait = 1'b0;
        endcase
    end

    assign wait_clear = !mem_wait;
    assign wait_en    = mem_wait && !bus.MemReady;

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (Clock),
        .rst     (Clear),
        .clear   (wait_clear),
        .enable  (wait_en),
        .expired (expired)
    );

    // MemReady is tested before expired so a late ready still completes
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state <= S_RST;
        end else begin
            case (state)
                S_RST: state <= S_T0;
                S_T0:  state <= S_T1;
                S_T1, S_T1W: begin
                    if (bus.MemReady)  state <= S_T2;
                    else if (expired)  state <= S_FAULT;
                    else               state <= S_T1W;
                end
                S_T2:  state <= S_T3;
                S_T3: begin
                    case (op_class)
                        C_HALT:           state <= S_HALT;
                        C_NOP, C_ILLEGAL: state <= S_T0;
                        default:          state <= S_T4;
                    endcase
                end
                S_T4:  state <= S_T5;
                S_T5: begin
                    case (op_class)
                        C_ALU, C_ADDI: state <= S_T0;
                        default:       state <= S_T6;
                    endcase
                end
                S_T6: begin
                    case (op_class)
                        C_LD: begin
                            if (bus.MemReady) state <= S_T7;
                            else if (expired) state <= S_FAULT;
                        end
                        C_ST:    state <= S_T7;
                        default: state <= S_T0;
                    endcase
                end
                S_T7: begin
                    case (op_class)
                        C_ST: begin
                            if (bus.MemReady) state <= S_T0;
                            else if (expired) state <= S_FAULT;
                        end
                        default: state <= S_T0;
                    endcase
                end
                S_HALT:  state <= S_HALT;
                S_FAULT: state <= S_FAULT;
                default: state <= S_RST;
            endcase
        end
    end

    // Moore decode of state and opcode into the control word
    always_comb begin
        ctl        = '0;
        ctl.alu_op = ALU_ADD;
        ctl.run    = !(state inside {S_RST, S_HALT, S_FAULT});
        case (state)
            S_T0: begin
                ctl.pc_out = 1'b1;
                ctl.mar_in = 1'b1;
                ctl.inc_pc = 1'b1;
                ctl.z_in   = 1'b1;
            end
            S_T1: begin
                ctl.zlow_out = 1'b1;
                ctl.pc_in    = 1'b1;
                ctl.read     = 1'b1;
                ctl.mdr_in   = 1'b1;
            end
            S_T1W: begin
                ctl.read   = 1'b1;
                ctl.mdr_in = 1'b1;
            end
            S_T2: begin
                ctl.mdr_out = 1'b1;
                ctl.ir_in   = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    C_ALU, C_ADDI: begin
                        ctl.grb   = 1'b1;
                        ctl.r_out = 1'b1;
                        ctl.y_in  = 1'b1;
                    end
                    C_LD, C_ST: begin
                        ctl.grb    = 1'b1;
                        ctl.ba_out = 1'b1;
                        ctl.y_in   = 1'b1;
                    end
                    C_BR: begin
                        ctl.gra    = 1'b1;
                        ctl.r_out  = 1'b1;
                        ctl.con_in = 1'b1;
                    end
                    C_MULDIV: begin
                        ctl.gra   = 1'b1;
                        ctl.r_out = 1'b1;
                        ctl.y_in  = 1'b1;
                    end
                    C_ILLEGAL: ctl.illegal_op = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (op_class)
                    C_ALU: begin
                        ctl.grc    = 1'b1;
                        ctl.r_out  = 1'b1;
                        ctl.alu_op = alu_for_op(opcode);
                        ctl.z_in   = 1'b1;
                    end
                    C_ADDI, C_LD, C_ST: begin
                        ctl.c_out = 1'b1;
                        ctl.z_in  = 1'b1;
                    end
                    C_BR: begin
                        ctl.pc_out = 1'b1;
                        ctl.y_in   = 1'b1;
                    end
                    C_MULDIV: begin
                        ctl.grb    = 1'b1;
                        ctl.r_out  = 1'b1;
                        ctl.alu_op = alu_for_op(opcode);
                        ctl.z_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_class)
                    C_ALU, C_ADDI: begin
                        ctl.zlow_out = 1'b1;
                        ctl.gra      = 1'b1;
                        ctl.r_in     = 1'b1;
                    end
                    C_LD, C_ST: begin
                        ctl.zlow_out = 1'b1;
                        ctl.mar_in   = 1'b1;
                    end
                    C_BR: begin
                        ctl.c_out = 1'b1;
                        ctl.z_in  = 1'b1;
                    end
                    C_MULDIV: begin
                        ctl.zlow_out = 1'b1;
                        ctl.lo_in    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op_class)
                    C_LD: begin
                        ctl.read   = 1'b1;
                        ctl.mdr_in = 1'b1;
                    end
                    C_ST: begin
                        ctl.gra    = 1'b1;
                        ctl.r_out  = 1'b1;
                        ctl.mdr_in = 1'b1;
                    end
                    C_BR: begin
                        ctl.zlow_out = 1'b1;
                        ctl.pc_in    = bus.CON;
                    end
                    C_MULDIV: begin
                        ctl.zhi_out = 1'b1;
                        ctl.hi_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op_class)
                    C_LD: begin
                        ctl.mdr_out = 1'b1;
                        ctl.gra     = 1'b1;
                        ctl.r_in    = 1'b1;
                    end
                    C_ST:    ctl.write = 1'b1;
                    default: ;
                endcase
            end
            S_FAULT: ctl.fault = 1'b1;
            default: ;
        endcase
    end

    assign bus.PCout     = ctl.pc_out;
    assign bus.Zlowout   = ctl.zlow_out;
    assign bus.MDRout    = ctl.mdr_out;
    assign bus.Cout      = ctl.c_out;
    assign bus.BAout     = ctl.ba_out;
    assign bus.Rout      = ctl.r_out;
    assign bus.MARin     = ctl.mar_in;
    assign bus.Zin       = ctl.z_in;
    assign bus.PCin      = ctl.pc_in;
    assign bus.MDRin     = ctl.mdr_in;
    assign bus.IRin      = ctl.ir_in;
    assign bus.Yin       = ctl.y_in;
    assign bus.Rin       = ctl.r_in;
    assign bus.CONIn     = ctl.con_in;
    assign bus.Gra       = ctl.gra;
    assign bus.Grb       = ctl.grb;
    assign bus.Grc       = ctl.grc;
    assign bus.IncPC     = ctl.inc_pc;
    assign bus.Read      = ctl.read;
    assign bus.Write     = ctl.write;
    assign bus.AluOp     = ctl.alu_op;
    assign bus.Run       = ctl.run;
    assign bus.Fault     = ctl.fault;
    assign bus.IllegalOp = ctl.illegal_op;

`ifdef CTRL_MULDIV_EN
    assign bus.Zhiout = ctl.zhi_out;
    assign bus.HIin   = ctl.hi_in;
    assign bus.LOin   = ctl.lo_in;
`else
    assign bus.Zhiout = 1'b0;
    assign bus.HIin   = 1'b0;
    assign bus.LOin   = 1'b0;

    logic unused_muldiv;
    assign unused_muldiv = ^{ctl.zhi_out, ctl.hi_in, ctl.lo_in};
`endif

endmodule
